// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result bundle between the control unit and the
// sequential multiplier.
//   start, sgn, a, b, rd_hilo : driven by the control unit (master)
//   busy, stall, done, hi, lo : driven by the multiplier (slave)
interface mult_seq_if;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, sgn, a, b, rd_hilo,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, sgn, a, b, rd_hilo,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: 32x32 -> 64 radix-2 shift-add multiplier for mult/multu.
// A request costs 34 cycles from the accepting edge up to and including
// the edge that writes hi/lo, independent of operand values.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_seq_if.slave
//             start/sgn/a/b : request and operands, sampled in IDLE/DONE
//             rd_hilo       : current instruction reads hi/lo
//             busy          : RUN or FIX
//             stall         : busy & (start | rd_hilo), combinational
//             done          : one-cycle pulse, hi/lo just updated
//             hi/lo         : product [63:32] / [31:0]
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | 32 shift-add steps, one multiplier bit per cycle
// FIX    | apply sign to the magnitude product, write hi/lo
// DONE   | done pulse; a new start is accepted here as in IDLE
module mult_seq (
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc_q;
  logic [5:0]  cnt_q;
  logic        neg_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] a_abs_d;
  logic [31:0] b_abs_d;
  logic [32:0] sum_d;
  logic [63:0] fix_d;

  // Negating 0x80000000 in 32 bits gives 0x80000000 back, which read as
  // unsigned is exactly 2^31, so the most negative operand needs no extra bit.
  assign a_abs_d = (bus.sgn && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_abs_d = (bus.sgn && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  // Right-shifting accumulator: the multiplicand is added into the upper
  // half, and the carry out becomes the new MSB after the shift.
  assign sum_d = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);

  assign fix_d = neg_q ? (~acc_q + 64'd1) : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_q     <= a_abs_d;
            b_q     <= b_abs_d;
            neg_q   <= bus.sgn & (bus.a[31] ^ bus.b[31]);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q <= {sum_d, acc_q[31:1]};
          b_q   <= {1'b0, b_q[31:1]};
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          acc_q   <= fix_d;
          hi_q    <= fix_d[63:32];
          lo_q    <= fix_d[31:0];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_hilo);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  mult_seq_if bus ();

  mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from the current cycle and waits for done.
  // Leaves time parked in the DONE cycle so the caller can start again there.
  task automatic run_op(input string nm, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh,
                        input logic [31:0] el);
    int          n;
    int          busy_n;
    logic        hold_ok;
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.sgn   = s;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'hCAFE_F00D;
    n = 0;
    busy_n = 0;
    hold_ok = 1'b1;
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_n++;
      if (bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
      step();
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd33);
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'd33);
    chk({nm, " hilo_hold"}, 64'(hold_ok), 64'd1);
    chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
    chk({nm, " lo"}, 64'(bus.lo), 64'(el));
  endtask

  initial begin
    int          n;
    logic        stall_ok;
    logic        exp_st;

    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{"u7x6",        1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A};
    vecs[1]  = '{"umax",        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{"s_m3x5",      1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[3]  = '{"s_min_min",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4]  = '{"u_zero",      1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{"s_min_x1",    1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6]  = '{"u_2p31x2",    1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{"s_m1xm1",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[8]  = '{"u_2p16sq",    1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{"s_7xm6",      1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[10] = '{"u_shift4",    1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};

    bus.start   = 1'b0;
    bus.sgn     = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.rd_hilo = 1'b0;
    rst_n       = 1'b0;
    #23;
    chk("rst busy",  64'(bus.busy),  64'd0);
    chk("rst stall", 64'(bus.stall), 64'd0);
    chk("rst done",  64'(bus.done),  64'd0);
    chk("rst hilo",  {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo);
      step();
      chk({vecs[i].name, " idle_done"}, 64'(bus.done), 64'd0);
    end

    // rd_hilo hazard plus an ignored second start while busy
    bus.sgn = 1'b0;
    bus.a = 32'd100;
    bus.b = 32'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    do begin
      step();
      n++;
      if (n == 2) bus.rd_hilo = 1'b1;
      if (n == 10) begin
        bus.start = 1'b1;
        bus.a = 32'd5;
        bus.b = 32'd5;
      end
      if (n == 11) bus.start = 1'b0;
      #1;
      if (!bus.done) begin
        exp_st = (n >= 2);
        if (bus.stall !== exp_st) stall_ok = 1'b0;
      end
    end while (!bus.done && n < 100);
    chk("haz latency", 64'(n), 64'd33);
    chk("haz stall_window", 64'(stall_ok), 64'd1);
    chk("haz stall_done", 64'(bus.stall), 64'd0);
    chk("haz hilo", {bus.hi, bus.lo}, 64'd300);
    bus.rd_hilo = 1'b0;
    step();
    chk("haz idle_hilo", {bus.hi, bus.lo}, 64'd300);

    // reset in the middle of RUN
    run_op("pre_rst", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
    step();
    bus.sgn = 1'b0;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (15) step();
    bus.start = 1'b1;
    bus.rd_hilo = 1'b1;
    #1;
    chk("mid_run stall", 64'(bus.stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst busy",  64'(bus.busy),  64'd0);
    chk("arst stall", 64'(bus.stall), 64'd0);
    chk("arst hilo",  {bus.hi, bus.lo}, 64'd0);
    bus.start = 1'b0;
    bus.rd_hilo = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst idle", 64'(bus.busy), 64'd0);
    run_op("u2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

    // back-to-back: second request presented in the DONE cycle
    step();
    run_op("b2b_first", 1'b0, 32'd4, 32'd5, 32'd0, 32'd20);
    chk("b2b in_done", 64'(bus.done), 64'd1);
    run_op("b2b_second", 1'b0, 32'd1, 32'd1, 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
